rv32im_lsu: RTL
===============

RV32IM_LSU -- requirements
Module: rv32im_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, legal 1..255: maximum number of WAIT cycles before a timeout error.
REQ-002 SHALL take data widths from the shared definitions: `API_DATA_WIDTH = 32 and `LSU_OPCODE_WIDTH.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 valid_i  in  1  memory operation presented by the EXU; held with stable operands until done_o.
REQ-006 lsu_opcode_i  in  `LSU_OPCODE_WIDTH  `LSU_OPCODE_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW.
REQ-007 val_memaddr_i  in  32  byte address from the EXU.
REQ-008 val_memdatawr_i  in  32  store data from the EXU, right-aligned.
REQ-009 val_memdatard_o  out  32  load result to the EXU, extended; 0 for stores and errors.
REQ-010 done_o  out  1  one-cycle completion pulse.
REQ-011 stall_o  out  1  pipeline hold request.
REQ-012 err_o  out  1  qualifies done_o as failed.
REQ-013 err_cause_o  out  2  00 none, 01 misaligned, 10 bus error, 11 timeout.
REQ-014 dmem_req_o  out  1  memory request, held until ack or error.
REQ-015 dmem_we_o  out  1  1 = write.
REQ-016 dmem_addr_o  out  32  word address: {addr[31:2], 2'b00}.
REQ-017 dmem_be_o  out  4  byte enables.
REQ-018 dmem_wdata_o  out  32  lane-replicated store data.
REQ-019 dmem_ack_i  in  1  memory completion.
REQ-020 dmem_err_i  in  1  memory bus error.
REQ-021 dmem_rdata_i  in  32  read word, valid with dmem_ack_i.

Function
REQ-022 SHALL implement an FSM with states IDLE, WAIT and DONE.
REQ-023 IDLE behaviour:
- valid_i=1 with a non-NONE, aligned opcode: SHALL latch opcode, address and data, and go to WAIT.
- valid_i=1 with NONE: SHALL be ignored, stall_o=0.
- valid_i=0: SHALL remain in IDLE.
REQ-024 Misalignment in IDLE:
- misaligned = half-word op with addr[0]=1, or word op with addr[1:0]≠0.
- SHALL go directly to DONE with err_cause_o=01.
- SHALL issue no dmem_req_o.
REQ-025 WAIT behaviour:
- dmem_req_o=1 and all dmem_* outputs SHALL be driven from latched values.
- dmem_req_o SHALL stay asserted until dmem_ack_i or dmem_err_i is sampled high.
REQ-026 Minimum latency SHALL be 2 cycles: valid_i accepted at edge N, ack sampled at edge N+1, done_o high in cycle N+1..N+2.
REQ-027 On dmem_ack_i=1 in WAIT: SHALL capture the formatted rdata and go to DONE.
REQ-028 On dmem_err_i=1 in WAIT: SHALL go to DONE with cause 10; dmem_err_i SHALL take priority when asserted together with dmem_ack_i.
REQ-029 Timeout counter:
- 8-bit counter, cleared on entry to WAIT, increments each WAIT cycle without ack or error.
- When it equals TIMEOUT_CYCLES, SHALL drop dmem_req_o and go to DONE with cause 11.
REQ-030 DONE SHALL last exactly one cycle:
- done_o=1, and err_o=1 iff cause≠00.
- valid_i SHALL be ignored in DONE.
- next state SHALL be IDLE unconditionally.
REQ-031 stall_o SHALL equal (IDLE & valid_i & opcode≠NONE) | WAIT, combinationally, and SHALL be 0 in DONE.
REQ-032 val_memdatard_o, err_o and err_cause_o SHALL hold their DONE values until the next operation is accepted.
REQ-033 Store formatting:
- SB: wdata = byte replicated ×4, be = 4'b0001 << addr[1:0].
- SH: wdata = half replicated ×2, be = 4'b0011 << {addr[1],1'b0}.
- SW: wdata = data, be = 4'b1111.
REQ-034 Loads SHALL drive dmem_we_o=0, be=4'b1111, wdata=0.
REQ-035 Load formatting:
- Select the byte using addr[1:0] and the half-word using addr[1].
- LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass the word.
REQ-036 While idle, dmem_addr_o, dmem_be_o and dmem_wdata_o SHALL be 0.

Reset
REQ-037 On rst_n_i low, asynchronously:
- state SHALL be IDLE and the counter 0.
- every output SHALL be 0 (stall_o follows REQ-031).
REQ-038 Reset during WAIT SHALL drop dmem_req_o immediately and SHALL generate no done_o; an ack arriving after reset SHALL be ignored.

Verification
REQ-039 LW: addr 0x100, ack 1 cycle after req with rdata 0xDEADBEEF -> dmem_addr_o=0x100, be=1111, done_o pulse, val_memdatard_o=0xDEADBEEF, err_o=0, total 2 cycles.
REQ-040 LB and LBU at addr 0x103 with rdata 0x80FF_1234 -> LB gives 0xFFFFFF80, LBU gives 0x00000080.
REQ-041 SH: addr 0x22, data 0x0000ABCD -> we=1, be=1100, wdata=0xABCDABCD, addr 0x20, done_o after ack.
REQ-042 LW at addr 0x102 -> no dmem_req_o, done_o next cycle, err_o=1, err_cause_o=01, rdata 0.
REQ-043 TIMEOUT_CYCLES=4, no ack -> req high for 4 cycles then low, done_o with cause 11; separately, dmem_err_i with ack -> cause 10.
REQ-044 rst_n_i low mid-WAIT -> req and stall_o drop in the same cycle, no done_o; a fresh LW after release completes normally.

Source files
------------

// File: rtl/rv32im_lsu_if.sv
// RV32IM load/store unit: data-memory bus bundle.
// Master side is the LSU, slave side is the memory.
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`define LSU_OPCODE_NONE  4'd0
`define LSU_OPCODE_LB    4'd1
`define LSU_OPCODE_LH    4'd2
`define LSU_OPCODE_LW    4'd3
`define LSU_OPCODE_LBU   4'd4
`define LSU_OPCODE_LHU   4'd5
`define LSU_OPCODE_SB    4'd6
`define LSU_OPCODE_SH    4'd7
`define LSU_OPCODE_SW    4'd8
`endif

interface rv32im_lsu_if;
  logic                       dmem_req_o;
  logic                       dmem_we_o;
  logic [`API_DATA_WIDTH-1:0] dmem_addr_o;
  logic [3:0]                 dmem_be_o;
  logic [`API_DATA_WIDTH-1:0] dmem_wdata_o;
  logic                       dmem_ack_i;
  logic                       dmem_err_i;
  logic [`API_DATA_WIDTH-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o,
    output dmem_be_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_err_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o,
    input  dmem_be_o, dmem_wdata_o,
    output dmem_ack_i, dmem_err_i, dmem_rdata_i
  );
endinterface

// File: rtl/rv32im_lsu.sv
// RV32IM load/store unit: one outstanding access, IDLE/WAIT/DONE FSM,
// misalignment, bus-error and timeout reporting.
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`define LSU_OPCODE_NONE  4'd0
`define LSU_OPCODE_LB    4'd1
`define LSU_OPCODE_LH    4'd2
`define LSU_OPCODE_LW    4'd3
`define LSU_OPCODE_LBU   4'd4
`define LSU_OPCODE_LHU   4'd5
`define LSU_OPCODE_SB    4'd6
`define LSU_OPCODE_SH    4'd7
`define LSU_OPCODE_SW    4'd8
`endif

module rv32im_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         valid_i,
  input  logic [`LSU_OPCODE_WIDTH-1:0] lsu_opcode_i,
  input  logic [`API_DATA_WIDTH-1:0]   val_memaddr_i,
  input  logic [`API_DATA_WIDTH-1:0]   val_memdatawr_i,
  output logic [`API_DATA_WIDTH-1:0]   val_memdatard_o,
  output logic                         done_o,
  output logic                         stall_o,
  output logic                         err_o,
  output logic [1:0]                   err_cause_o,
  rv32im_lsu_if.master                 dmem
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state_q, state_n;

  logic [`LSU_OPCODE_WIDTH-1:0] op_q;
  logic [`API_DATA_WIDTH-1:0]   addr_q;
  logic [`API_DATA_WIDTH-1:0]   data_q;
  logic [`API_DATA_WIDTH-1:0]   rd_q;
  logic [1:0]                   cause_q;
  logic [7:0]                   cnt_q;

  logic is_half, is_word, misal;
  logic accept, timeout, in_wait;
  logic is_store;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    unique case (lsu_opcode_i)
      `LSU_OPCODE_LH,
      `LSU_OPCODE_LHU,
      `LSU_OPCODE_SH: is_half = 1'b1;
      `LSU_OPCODE_LW,
      `LSU_OPCODE_SW: is_word = 1'b1;
      default: ;
    endcase
  end

  assign misal = (is_half & val_memaddr_i[0])
               | (is_word & |val_memaddr_i[1:0]);

  assign accept  = (state_q == IDLE) & valid_i
                 & (lsu_opcode_i != `LSU_OPCODE_NONE);
  assign in_wait = (state_q == WAIT);
  // Once the limit is hit the request is withdrawn; a late ack is ignored.
  assign timeout = in_wait & (cnt_q == TO_LIMIT);

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: if (accept) state_n = misal ? DONE : WAIT;
      WAIT: begin
        if (timeout | dmem.dmem_err_i | dmem.dmem_ack_i)
          state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_n;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q   <= `LSU_OPCODE_NONE;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_q   <= lsu_opcode_i;
      addr_q <= val_memaddr_i;
      data_q <= val_memdatawr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (in_wait & ~timeout
               & ~dmem.dmem_ack_i & ~dmem.dmem_err_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_q    <= '0;
      cause_q <= 2'b00;
    end else if (accept) begin
      rd_q    <= '0;
      cause_q <= misal ? 2'b01 : 2'b00;
    end else if (timeout) begin
      cause_q <= 2'b11;
    end else if (in_wait & dmem.dmem_err_i) begin
      cause_q <= 2'b10;
    end else if (in_wait & dmem.dmem_ack_i) begin
      rd_q    <= load_fmt;
    end
  end

  always_comb begin
    is_store = 1'b0;
    st_be    = 4'b1111;
    st_wdata = '0;
    unique case (op_q)
      `LSU_OPCODE_SB: begin
        is_store = 1'b1;
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{data_q[7:0]}};
      end
      `LSU_OPCODE_SH: begin
        is_store = 1'b1;
        st_be    = 4'b0011 << {addr_q[1], 1'b0};
        st_wdata = {2{data_q[15:0]}};
      end
      `LSU_OPCODE_SW: begin
        is_store = 1'b1;
        st_wdata = data_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    byte_sel = dmem.dmem_rdata_i[7:0];
      2'd1:    byte_sel = dmem.dmem_rdata_i[15:8];
      2'd2:    byte_sel = dmem.dmem_rdata_i[23:16];
      default: byte_sel = dmem.dmem_rdata_i[31:24];
    endcase
    half_sel = addr_q[1] ? dmem.dmem_rdata_i[31:16]
                         : dmem.dmem_rdata_i[15:0];
    load_fmt = '0;
    unique case (op_q)
      `LSU_OPCODE_LB:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      `LSU_OPCODE_LH:  load_fmt = {{16{half_sel[15]}}, half_sel};
      `LSU_OPCODE_LW:  load_fmt = dmem.dmem_rdata_i;
      `LSU_OPCODE_LBU: load_fmt = {24'd0, byte_sel};
      `LSU_OPCODE_LHU: load_fmt = {16'd0, half_sel};
      default:         load_fmt = '0;
    endcase
  end

  logic req;
  assign req = in_wait & ~timeout;

  assign dmem.dmem_req_o   = req;
  assign dmem.dmem_we_o    = req & is_store;
  assign dmem.dmem_addr_o  = req ? {addr_q[31:2], 2'b00} : '0;
  assign dmem.dmem_be_o    = req ? st_be : 4'b0000;
  assign dmem.dmem_wdata_o = req ? st_wdata : '0;

  assign done_o          = (state_q == DONE);
  assign stall_o         = accept | in_wait;
  assign err_o           = |cause_q;
  assign err_cause_o     = cause_q;
  assign val_memdatard_o = rd_q;

endmodule
